// File: rtl/debounce_pkg.sv
// Shared types, constants and helpers for the push-button conditioner.
package debounce_pkg;

  // Per-channel long-press state, exposed on the debug port.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_HOLD = 2'd1,
    REPEAT    = 2'd2
  } hold_state_t;

  localparam int DEF_N_CH          = 5;
  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_STABLE_CYCLES = 1000;
  localparam int DEF_HOLD_CYCLES   = 50_000_000;
  localparam int DEF_REPEAT_CYCLES = 10_000_000;

  // Bits needed to index 'value' distinct states; never less than 1 so
  // that degenerate parameter choices still yield a legal vector width.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((longint'(1) << r) < longint'(value)) r++;
    if (r < 1) r = 1;
    return r;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button: synchroniser, stability-counter debouncer and long-press /
// auto-repeat FSM. The input is expected already polarity-corrected.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        x,
  output logic        clean,
  output logic        rise,
  output logic        fall,
  output logic        hold,
  output hold_state_t state_dbg
);

  localparam int CW = clog2(STABLE_CYCLES + 1);
  localparam int HW = clog2(max2(HOLD_CYCLES, REPEAT_CYCLES) + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_V   = HW'(HOLD_CYCLES);
  localparam logic [HW-1:0] REP_V    = HW'(REPEAT_CYCLES);
  localparam logic [HW-1:0] H_ONE    = HW'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   flip, rise_d, fall_d;
  hold_state_t            state_q, state_d;
  logic [HW-1:0]          hcnt_q, hcnt_d;
  logic                   hold_d;

  assign s = sync_q[SYNC_STAGES-1];

  // Metastability chain: shift the raw level through SYNC_STAGES flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], x};
  end

  // Count consecutive samples that disagree with clean; any agreeing
  // sample restarts the count, so short glitches never get through.
  always_comb begin
    cnt_d = cnt_q;
    flip  = 1'b0;
    if (s == clean) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      flip  = 1'b1;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign rise_d = flip & s;
  assign fall_d = flip & ~s;

  // Debounced level and its registered edge pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      clean <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (flip) clean <= s;
      rise  <= rise_d;
      fall  <= fall_d;
    end
  end

  // Hold FSM state, hold counter and registered hold pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hcnt_q  <= '0;
      hold    <= 1'b0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      hold    <= hold_d;
    end
  end

  // Long-press sequencing. The rise decision is taken on the same edge
  // that sets clean, so hcnt equals the number of edges since that rise.
  // A pending fall suppresses the pulse so hold never lands with fall.
  // With no repeat, hcnt parks at 0 after the single pulse; it can never
  // equal HOLD_CYCLES (>=1) again until the next press reloads it.
  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    hold_d  = 1'b0;
    if (HOLD_CYCLES == 0) begin
      state_d = IDLE;
      hcnt_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rise_d) begin
            state_d = WAIT_HOLD;
            hcnt_d  = H_ONE;
          end
        end
        WAIT_HOLD: begin
          if (!clean) begin
            state_d = rise_d ? WAIT_HOLD : IDLE;
            hcnt_d  = rise_d ? H_ONE : '0;
          end else if (fall_d) begin
            hcnt_d = hcnt_q;
          end else if (hcnt_q == HOLD_V) begin
            hold_d = 1'b1;
            if (REPEAT_CYCLES > 0) begin
              state_d = REPEAT;
              hcnt_d  = H_ONE;
            end else begin
              hcnt_d = '0;
            end
          end else if (hcnt_q != '0) begin
            hcnt_d = hcnt_q + H_ONE;
          end
        end
        REPEAT: begin
          if (!clean) begin
            state_d = rise_d ? WAIT_HOLD : IDLE;
            hcnt_d  = rise_d ? H_ONE : '0;
          end else if (fall_d) begin
            hcnt_d = hcnt_q;
          end else if (hcnt_q == REP_V) begin
            hold_d = 1'b1;
            hcnt_d = H_ONE;
          end else begin
            hcnt_d = hcnt_q + H_ONE;
          end
        end
        default: begin
          state_d = IDLE;
          hcnt_d  = '0;
        end
      endcase
    end
  end

  assign state_dbg = state_q;

endmodule

// File: rtl/debounce_bank.sv
// N independent button conditioners on the system clock. INVERT folds
// active-low buttons to active-high before synchronisation. state_dbg
// carries each channel's hold FSM state, two bits per channel.
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int              N_CH          = DEF_N_CH,
  parameter int              SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int              STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int              HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int              REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter logic [N_CH-1:0] INVERT        = {N_CH{1'b0}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_CH-1:0]   btn_in,
  output logic [N_CH-1:0]   clean,
  output logic [N_CH-1:0]   rise,
  output logic [N_CH-1:0]   fall,
  output logic [N_CH-1:0]   hold,
  output logic [2*N_CH-1:0] state_dbg
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    hold_state_t st;

    debounce_channel #(
      .SYNC_STAGES  (SYNC_STAGES),
      .STABLE_CYCLES(STABLE_CYCLES),
      .HOLD_CYCLES  (HOLD_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .x        (btn_in[i] ^ INVERT[i]),
      .clean    (clean[i]),
      .rise     (rise[i]),
      .fall     (fall[i]),
      .hold     (hold[i]),
      .state_dbg(st)
    );

    assign state_dbg[2*i +: 2] = st;
  end

endmodule

// File: tb/tb_debounce_bank.sv
// Self-checking bench for debounce_bank: directed scenarios plus random
// stimulus, all compared against a rule-level model of the conditioner.
module tb_debounce_bank;

  localparam int N  = 4;
  localparam int S  = 2;
  localparam int ST = 4;
  localparam int H  = 10;
  localparam int R  = 3;
  localparam logic [N-1:0] INV = 4'b1000;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] btn_in;
  logic [N-1:0] clean, rise, fall, hold;
  logic [2*N-1:0] state_dbg;

  int n_pass = 0;
  int n_total = 0;

  debounce_bank #(
    .N_CH(N), .SYNC_STAGES(S), .STABLE_CYCLES(ST),
    .HOLD_CYCLES(H), .REPEAT_CYCLES(R), .INVERT(INV)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_in(btn_in),
    .clean(clean), .rise(rise), .fall(fall), .hold(hold),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Rules: the synchronised sample is the polarity-corrected input from S
  // edges earlier; clean flips once ST consecutive samples since the last
  // flip disagree with it; hold fires when the age since rise reaches H
  // and every R edges after that, while clean stays high and is not
  // falling on that edge.
  logic [N-1:0] m_clean, m_rise, m_fall, m_hold;
  logic [N-1:0] m_x, m_s;
  logic [N-1:0] xq[$];
  int streak[N];
  int age[N];
  logic m_flip;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_clean = '0; m_rise = '0; m_fall = '0; m_hold = '0;
      xq = {};
      for (int i = 0; i < S; i++) xq.push_back('0);
      for (int c = 0; c < N; c++) begin streak[c] = 0; age[c] = 0; end
    end else begin
      m_x = btn_in ^ INV;
      xq.push_back(m_x);
      m_s = xq.pop_front();
      m_rise = '0; m_fall = '0; m_hold = '0;
      for (int c = 0; c < N; c++) begin
        m_flip = 1'b0;
        if (m_s[c] != m_clean[c]) begin
          streak[c]++;
          if (streak[c] == ST) m_flip = 1'b1;
        end else begin
          streak[c] = 0;
        end
        if (m_clean[c] && !m_flip) begin
          age[c]++;
          if (age[c] == H || (age[c] > H && (age[c] - H) % R == 0)) m_hold[c] = 1'b1;
        end
        if (m_flip) begin
          streak[c] = 0;
          m_clean[c] = m_s[c];
          if (m_s[c]) begin m_rise[c] = 1'b1; age[c] = 0; end
          else m_fall[c] = 1'b1;
        end
      end
    end
  end

  wire [4*N-1:0] dut_v = {clean, rise, fall, hold};
  wire [4*N-1:0] mdl_v = {m_clean, m_rise, m_fall, m_hold};

  // ---------------- driver tasks ----------------
  // Drive a raw level for channel c (logical press value, INVERT applied).
  task automatic press(input int c, input logic v);
    btn_in[c] = v ^ INV[c];
  endtask

  task automatic release_all();
    btn_in = INV;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int rise_at;
    logic [N-1:0] rise_seen, clean_seen;
    release_all();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_total++;
    if (dut_v !== '0 || state_dbg !== '0)
      $display("FAIL reset_por: outputs=%h dbg=%h required 0/0", dut_v, state_dbg);
    else n_pass++;
    rst_n = 1'b1;
    btn_in = ~INV;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      n_total++;
      if (dut_v !== mdl_v) $display("FAIL reset_press k=%0d: dut=%h model=%h", k, dut_v, mdl_v);
      else n_pass++;
    end
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if (dut_v !== '0 || state_dbg !== '0)
      $display("FAIL reset_async: outputs=%h dbg=%h required 0/0", dut_v, state_dbg);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    rise_at = 0; rise_seen = '0; clean_seen = '0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      n_total++;
      if (dut_v !== mdl_v) $display("FAIL reset_rel k=%0d: dut=%h model=%h", k, dut_v, mdl_v);
      else n_pass++;
      if (rise !== '0 && rise_at == 0) begin
        rise_at = k; rise_seen = rise; clean_seen = clean;
      end
    end
    n_total++;
    if (rise_at != 6 || rise_seen !== 4'hF || clean_seen !== 4'hF)
      $display("FAIL reset_held_rise: edge=%0d rise=%h clean=%h required 6/f/f", rise_at, rise_seen, clean_seen);
    else n_pass++;
    release_all();
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      n_total++;
      if (dut_v !== mdl_v) $display("FAIL reset_idle k=%0d: dut=%h model=%h", k, dut_v, mdl_v);
      else n_pass++;
    end
  endtask

  task automatic test_glitch();
    int nrise, rise_at, fall_at;
    nrise = 0;
    for (int k = 1; k <= 14; k++) begin
      press(0, k <= 3);
      @(negedge clk);
      if (rise[0] === 1'b1 || clean[0] === 1'b1) nrise++;
      n_total++;
      if (dut_v !== mdl_v) $display("FAIL glitch3 k=%0d: dut=%h model=%h", k, dut_v, mdl_v);
      else n_pass++;
    end
    n_total++;
    if (nrise != 0) $display("FAIL glitch3_reject: clean/rise high %0d cycles, required 0", nrise);
    else n_pass++;
    rise_at = 0; fall_at = 0;
    for (int k = 1; k <= 16; k++) begin
      press(0, k <= 4);
      @(negedge clk);
      if (rise[0] === 1'b1) rise_at = k;
      if (fall[0] === 1'b1) fall_at = k;
      n_total++;
      if (dut_v !== mdl_v) $display("FAIL glitch4 k=%0d: dut=%h model=%h", k, dut_v, mdl_v);
      else n_pass++;
    end
    n_total++;
    if (rise_at != 6 || fall_at != 10)
      $display("FAIL glitch4_edges: rise@%0d fall@%0d required rise@6 fall@10", rise_at, fall_at);
    else n_pass++;
  endtask

  task automatic test_bounce();
    logic [8:0] pat;
    int nrise, rise_at, nhold, fall_at;
    pat = 9'b111101101;  // bit k-1 drives edge k: 1,0,1,1,0,1,1,1,1
    nrise = 0; rise_at = 0; nhold = 0; fall_at = 0;
    for (int k = 1; k <= 28; k++) begin
      if (k <= 9) press(1, pat[k-1]);
      else        press(1, k <= 15);
      @(negedge clk);
      if (rise[1] === 1'b1) begin nrise++; rise_at = k; end
      if (hold[1] === 1'b1) nhold++;
      if (fall[1] === 1'b1) fall_at = k;
      n_total++;
      if (dut_v !== mdl_v) $display("FAIL bounce k=%0d: dut=%h model=%h", k, dut_v, mdl_v);
      else n_pass++;
    end
    n_total++;
    if (nrise != 1 || rise_at != 11)
      $display("FAIL bounce_rise: count=%0d edge=%0d required 1 at 11", nrise, rise_at);
    else n_pass++;
    // fall lands exactly where the first hold would: the hold must be dropped
    n_total++;
    if (fall_at != 21 || nhold != 0)
      $display("FAIL bounce_fall_vs_hold: fall@%0d holds=%0d required fall@21 holds=0", fall_at, nhold);
    else n_pass++;
  endtask

  task automatic test_long_press();
    logic [7:0] exp_q[$];
    logic [7:0] got;
    int rise_at, fall_at, late;
    exp_q = {8'd10, 8'd13, 8'd16, 8'd19, 8'd22, 8'd25, 8'd28};
    rise_at = 0; fall_at = 0; late = 0;
    for (int k = 1; k <= 45; k++) begin
      press(2, k <= 30);
      @(negedge clk);
      if (rise[2] === 1'b1) rise_at = k;
      if (fall[2] === 1'b1) fall_at = k;
      if (hold[2] === 1'b1) begin
        got = 8'(k - rise_at);
        if (fall_at != 0) late++;
        n_total++;
        if (exp_q.size() == 0) $display("FAIL long_hold_extra: offset %0d, required none", got);
        else begin
          if (got !== exp_q[0]) $display("FAIL long_hold_offset: got %0d required %0d", got, exp_q[0]);
          else n_pass++;
          void'(exp_q.pop_front());
        end
      end
      n_total++;
      if (dut_v !== mdl_v) $display("FAIL long k=%0d: dut=%h model=%h", k, dut_v, mdl_v);
      else n_pass++;
    end
    n_total++;
    if (exp_q.size() != 0 || late != 0 || rise_at != 6 || fall_at != 36)
      $display("FAIL long_summary: missing=%0d after_fall=%0d rise@%0d fall@%0d required 0/0/6/36",
               exp_q.size(), late, rise_at, fall_at);
    else n_pass++;
  endtask

  task automatic test_release_before_hold();
    int nhold, fall_at;
    nhold = 0; fall_at = 0;
    for (int k = 1; k <= 30; k++) begin
      press(2, k <= 9);
      @(negedge clk);
      if (hold[2] === 1'b1) nhold++;
      if (fall[2] === 1'b1) fall_at = k;
      n_total++;
      if (dut_v !== mdl_v) $display("FAIL early_rel k=%0d: dut=%h model=%h", k, dut_v, mdl_v);
      else n_pass++;
    end
    n_total++;
    if (nhold != 0 || fall_at != 15 || state_dbg[5:4] !== 2'd0)
      $display("FAIL early_rel_hold: holds=%0d fall@%0d state=%0d required 0/15/0",
               nhold, fall_at, state_dbg[5:4]);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    logic [N-1:0] rise_seen;
    int rise_at;
    release_all();
    @(negedge clk);
    n_total++;
    if (btn_in[3] !== 1'b1 || clean[3] !== 1'b0)
      $display("FAIL invert_idle: btn=%b clean=%b required 1/0", btn_in[3], clean[3]);
    else n_pass++;
    rise_at = 0; rise_seen = '0;
    for (int k = 1; k <= 20; k++) begin
      press(0, k <= 8);
      press(3, k <= 8);
      @(negedge clk);
      if (rise !== '0 && rise_at == 0) begin rise_at = k; rise_seen = rise; end
      n_total++;
      if (dut_v !== mdl_v) $display("FAIL simul k=%0d: dut=%h model=%h", k, dut_v, mdl_v);
      else n_pass++;
    end
    n_total++;
    if (rise_at != 6 || rise_seen !== 4'b1001)
      $display("FAIL simul_rise: edge=%0d rise=%b required 6/1001", rise_at, rise_seen);
    else n_pass++;
  endtask

  task automatic test_random();
    int run[N];
    for (int c = 0; c < N; c++) run[c] = 0;
    for (int k = 0; k < 400; k++) begin
      for (int c = 0; c < N; c++) begin
        if (run[c] == 0) begin
          btn_in[c] = $urandom_range(0, 1);
          run[c] = $urandom_range(1, 20);
        end
        run[c]--;
      end
      rst_n = (k != 200);
      @(negedge clk);
      n_total++;
      if (dut_v !== mdl_v) $display("FAIL random k=%0d: dut=%h model=%h", k, dut_v, mdl_v);
      else n_pass++;
    end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    btn_in = INV;
    test_reset();
    test_glitch();
    test_bounce();
    test_long_press();
    test_release_before_hold();
    test_simultaneous();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete, %0d/%0d so far", n_pass, n_total);
    $fatal(1);
  end

endmodule
